// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: packet geometry, PID codes and enums shared by the
// USB TX scheduler and its users.
package usb_tx_pkg;

  localparam int PKT_W  = 99;
  localparam int PID_HI = 90;
  localparam int PID_LO = 83;

  localparam logic [7:0] OUTPID  = 8'hE1;
  localparam logic [7:0] INPID   = 8'h69;
  localparam logic [7:0] DATAPID = 8'hC3;
  localparam logic [7:0] ACKPID  = 8'hD2;
  localparam logic [7:0] NAKPID  = 8'h5A;

  typedef enum logic [1:0] {
    TYPE_NON,
    TYPE_TOK,
    TYPE_DATA,
    TYPE_HS
  } pkt_type_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_GAP
  } sched_state_t;

  function automatic pkt_type_t pid_type(input logic [7:0] pid);
    pkt_type_t t;
    case (pid)
      OUTPID,
      INPID:   t = TYPE_TOK;
      DATAPID: t = TYPE_DATA;
      ACKPID,
      NAKPID:  t = TYPE_HS;
      default: t = TYPE_NON;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/usb_tx_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request
// at or after ptr (wrapping). Ports: req, ptr -> grant (one-hot), idx, any.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any
);

  logic [IW:0] j;

  // Walk offsets from far to near so the nearest set bit is the
  // last one written and therefore wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = {1'b0, ptr} + (IW+1)'(i);
      if (j >= (IW+1)'(NUM_REQ)) begin
        j = j - (IW+1)'(NUM_REQ);
      end
      if (req[j[IW-1:0]]) begin
        grant             = '0;
        grant[j[IW-1:0]]  = 1'b1;
        idx               = j[IW-1:0];
        any               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_tx_scheduler.sv
// usb_tx_scheduler: shares one USB packet encoder between NUM_REQ
// packet sources. Grants round-robin, holds enc_pkt for the whole
// packet, drops enc_pkt_avail on enc_pkt_sent and then idles GAP_CYC
// cycles before the next grant.
// Ports: req_valid/req_pkt in, req_ack/req_done/req_err pulses out,
// enc_pkt/enc_pkt_avail to encoder, enc_pkt_sent back, busy, owner.
// Option: define USB_TX_TIMEOUT_EN to abort a packet after
// TIMEOUT_CYC SEND cycles without enc_pkt_sent.
module usb_tx_scheduler #(
  parameter int NUM_REQ     = 3,
  parameter int PKT_W       = 99,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 160,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0][PKT_W-1:0] req_pkt,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [NUM_REQ-1:0]            req_err,
  output logic [PKT_W-1:0]              enc_pkt,
  output logic                          enc_pkt_avail,
  input  logic                          enc_pkt_sent,
  output logic                          busy,
  output logic [IW-1:0]                 owner
);
  import usb_tx_pkg::*;

  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  sched_state_t         state_q, state_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [PKT_W-1:0]     enc_pkt_q, enc_pkt_d;
  logic                 avail_q, avail_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [NUM_REQ-1:0]   err_q, err_d;
  logic [GW-1:0]        gap_q, gap_d;

`ifdef USB_TX_TIMEOUT_EN
  localparam int WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [WW-1:0]        wd_q, wd_d;
`endif

  logic [NUM_REQ-1:0]   gnt;
  logic [IW-1:0]        gnt_idx;
  logic                 gnt_any;
  logic [IW-1:0]        ptr_nxt;
  logic [NUM_REQ-1:0]   owner_oh;
  logic                 pid_ok;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  assign ptr_nxt  = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
  assign pid_ok   = pid_type(enc_pkt_q[PID_HI:PID_LO]) != TYPE_NON;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    enc_pkt_d = enc_pkt_q;
    avail_d   = avail_q;
    gap_d     = gap_q;
    ack_d     = '0;
    done_d    = '0;
    err_d     = '0;
`ifdef USB_TX_TIMEOUT_EN
    wd_d      = wd_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          enc_pkt_d = req_pkt[gnt_idx];
          owner_d   = gnt_idx;
          rr_ptr_d  = ptr_nxt;
          ack_d     = gnt;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (pid_ok) begin
          avail_d = 1'b1;
          state_d = S_SEND;
`ifdef USB_TX_TIMEOUT_EN
          wd_d    = '0;
`endif
        end else begin
          err_d   = owner_oh;
          gap_d   = GW'(GAP_CYC - 1);
          state_d = S_GAP;
        end
      end
      S_SEND: begin
        if (enc_pkt_sent) begin
          avail_d = 1'b0;
          done_d  = owner_oh;
          gap_d   = GW'(GAP_CYC - 1);
          state_d = S_GAP;
        end
`ifdef USB_TX_TIMEOUT_EN
        else if (wd_q == WW'(TIMEOUT_CYC - 1)) begin
          avail_d = 1'b0;
          err_d   = owner_oh;
          gap_d   = GW'(GAP_CYC - 1);
          state_d = S_GAP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      enc_pkt_q <= '0;
      avail_q   <= 1'b0;
      ack_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      gap_q     <= '0;
`ifdef USB_TX_TIMEOUT_EN
      wd_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      enc_pkt_q <= enc_pkt_d;
      avail_q   <= avail_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      err_q     <= err_d;
      gap_q     <= gap_d;
`ifdef USB_TX_TIMEOUT_EN
      wd_q      <= wd_d;
`endif
    end
  end

  assign req_ack       = ack_q;
  assign req_done      = done_q;
  assign req_err       = err_q;
  assign enc_pkt       = enc_pkt_q;
  assign enc_pkt_avail = avail_q;
  assign owner         = owner_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// tb_usb_tx_scheduler: directed scenarios plus randomized traffic,
// checked by a scoreboard fed from a behavioural model of the scheduler.
module tb_usb_tx_scheduler;

  localparam int N   = 3;
  localparam int W   = 99;
  localparam int GAP = 4;
  localparam int TO  = 160;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N-1:0]          req_valid;
  logic [N-1:0][W-1:0]   req_pkt;
  logic [N-1:0]          req_ack, req_done, req_err;
  logic [W-1:0]          enc_pkt;
  logic                  enc_pkt_avail, enc_pkt_sent, busy;
  logic [1:0]            owner;

  usb_tx_scheduler #(
    .NUM_REQ     (N),
    .PKT_W       (W),
    .GAP_CYC     (GAP),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_pkt       (req_pkt),
    .req_ack       (req_ack),
    .req_done      (req_done),
    .req_err       (req_err),
    .enc_pkt       (enc_pkt),
    .enc_pkt_avail (enc_pkt_avail),
    .enc_pkt_sent  (enc_pkt_sent),
    .busy          (busy),
    .owner         (owner)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [7:0] good [5] = '{8'hE1, 8'h69, 8'hC3, 8'hD2, 8'h5A};

  function automatic bit pid_ok(input logic [7:0] p);
    return p inside {8'hE1, 8'h69, 8'hC3, 8'hD2, 8'h5A};
  endfunction

  function automatic logic [W-1:0] mk_pkt(input logic [7:0] pid);
    logic [127:0] r;
    logic [W-1:0] p;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    p = r[W-1:0];
    p[90:83] = pid;
    return p;
  endfunction

  function automatic logic [W-1:0] rand_pkt();
    logic [7:0] pid;
    if ($urandom_range(0, 3) != 0) pid = good[$urandom_range(0, 4)];
    else pid = 8'($urandom_range(0, 255));
    return mk_pkt(pid);
  endfunction

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [N-1:0] ack;
    logic [N-1:0] done;
    logic [N-1:0] err;
    logic [W-1:0] pkt;
    int           own;
  } ev_t;

  ev_t sb[$];
  ev_t ev;

  int e = 0, m_ready = 0, m_ptr = 0, m_own = 0, m_scnt = 0, w = 0;
  bit m_load = 0, m_send = 0, m_avail = 0, m_busy = 0;
  logic [W-1:0] m_pkt = '0;

  function automatic ev_t mk_ev(input int kind, input int who,
                                input logic [W-1:0] p);
    ev_t v;
    v.ack = '0; v.done = '0; v.err = '0; v.pkt = p; v.own = who;
    if (kind == 0) v.ack[who] = 1'b1;
    else if (kind == 1) v.done[who] = 1'b1;
    else v.err[who] = 1'b1;
    return v;
  endfunction

  // Model: one packet at a time; after it ends the encoder is idle GAP
  // cycles, then one idle edge, then the next grant may happen.
  always @(posedge clk) begin
    e++;
    if (rst) begin
      sb.delete();
      m_ptr = 0; m_ready = e + 1; m_load = 0; m_send = 0;
      m_avail = 0; m_pkt = '0; m_own = 0;
    end else if (m_load) begin
      m_load = 0;
      if (pid_ok(m_pkt[90:83])) begin
        m_send = 1; m_avail = 1; m_scnt = 0;
      end else begin
        sb.push_back(mk_ev(2, m_own, m_pkt));
        m_ready = e + 1 + GAP;
      end
    end else if (m_send) begin
      m_scnt++;
      if (enc_pkt_sent) begin
        sb.push_back(mk_ev(1, m_own, m_pkt));
        m_send = 0; m_avail = 0; m_ready = e + 1 + GAP;
      end
`ifdef USB_TX_TIMEOUT_EN
      else if (m_scnt == TO) begin
        sb.push_back(mk_ev(2, m_own, m_pkt));
        m_send = 0; m_avail = 0; m_ready = e + 1 + GAP;
      end
`endif
    end else if (e >= m_ready && req_valid != '0) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      m_own = w;
      m_pkt = req_pkt[w];
      m_ptr = (w + 1) % N;
      m_load = 1;
      sb.push_back(mk_ev(0, w, m_pkt));
    end
    m_busy = m_load || m_send || (e < m_ready - 1);
  end

  // Monitor: compare every pulse with the next expected event.
  always @(negedge clk) begin
    if (e > 0) begin
      chk("avail", enc_pkt_avail, m_avail);
      chk("busy", busy, m_busy);
      if (m_avail) chk("enc_pkt", enc_pkt, m_pkt);
      if ((req_ack | req_done | req_err) != '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {req_ack, req_done, req_err}, '0);
        end else begin
          ev = sb.pop_front();
          chk("pulse", {req_ack, req_done, req_err}, {ev.ack, ev.done, ev.err});
          if (ev.ack != '0) begin
            chk("ack_pkt", enc_pkt, ev.pkt);
            chk("owner", owner, ev.own);
          end
        end
      end else if (sb.size() != 0) begin
        ev = sb.pop_front();
        chk("missing_pulse", {req_ack, req_done, req_err},
            {ev.ack, ev.done, ev.err});
      end
    end
  end

  // ---------------- stimulus ----------------
  int  ack_log[$];
  int  hi_cnt, lo_run, min_gap, enc_wait, enc_lat;
  int  err_cnt [N];
  int  done_cnt[N];
  int  reload  [N];
  bit  seen_hi, enc_hang, enc_rand, stray, rand_mode, chg_on_ack;
  logic [7:0]   reload_pid;
  logic [W-1:0] p0;

  task automatic clear();
    ack_log.delete();
    hi_cnt = 0; lo_run = 0; min_gap = 1000; seen_hi = 0;
    for (int i = 0; i < N; i++) begin
      err_cnt[i] = 0; done_cnt[i] = 0; reload[i] = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (enc_pkt_avail === 1'b1) begin
      hi_cnt++;
      if (seen_hi && lo_run > 0 && lo_run < min_gap) min_gap = lo_run;
      seen_hi = 1; lo_run = 0;
    end else if (seen_hi) begin
      lo_run++;
    end
    for (int i = 0; i < N; i++) begin
      if (req_done[i] === 1'b1) done_cnt[i]++;
      if (req_err[i] === 1'b1) err_cnt[i]++;
      if (req_ack[i] === 1'b1) begin
        ack_log.push_back(i);
        if (reload[i] > 0) begin
          reload[i]--;
          req_pkt[i] = mk_pkt(reload_pid);
        end else begin
          req_valid[i] = 1'b0;
          if (chg_on_ack) req_pkt[i] = rand_pkt();
        end
      end
    end
    enc_pkt_sent = 1'b0;
    if (enc_pkt_avail === 1'b1) begin
      if (!enc_hang) begin
        if (enc_wait == 0) enc_pkt_sent = 1'b1;
        else enc_wait--;
      end
    end else begin
      enc_wait = enc_rand ? int'($urandom_range(0, 30)) : enc_lat;
      if (stray && $urandom_range(0, 15) == 0) enc_pkt_sent = 1'b1;
    end
    if (rand_mode) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 7) == 0) begin
          req_valid[i] = 1'b1;
          req_pkt[i]   = rand_pkt();
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    enc_pkt_sent = 1'b0;
    step();
    rst = 1'b0;
    clear();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_pkt = '0;
    enc_pkt_sent = 1'b0;
    enc_hang = 0; enc_rand = 0; stray = 0; rand_mode = 0; chg_on_ack = 0;
    enc_lat = 5; enc_wait = 0; reload_pid = 8'hD2;
    clear();
    step();
    chk("reset_avail", enc_pkt_avail, 1'b0);
    chk("reset_pulses", {req_ack, req_done, req_err, busy}, '0);
    chk("reset_pkt_owner", {enc_pkt, owner}, '0);
    step();
    rst = 1'b0;

    // single request, encoder answers after 24 avail cycles
    do_reset();
    enc_lat = 23;
    req_pkt[1] = mk_pkt(8'hE1);
    req_valid = 3'b010;
    step();
    chk("t1_ack_lat", req_ack, 3'b010);
    step();
    chk("t1_avail_lat", enc_pkt_avail, 1'b1);
    for (int c = 0; c < 58; c++) step();
    chk("t1_avail_cycles", hi_cnt, 24);
    chk("t1_done", done_cnt[1], 1);
    chk("t1_busy_end", busy, 1'b0);

    // all three valid with ACK packets, requester 0 re-requests
    do_reset();
    enc_lat = 6;
    reload_pid = 8'hD2;
    reload[0] = 1;
    for (int i = 0; i < N; i++) req_pkt[i] = mk_pkt(8'hD2);
    req_valid = '1;
    for (int c = 0; c < 200 &&
         (done_cnt[0] + done_cnt[1] + done_cnt[2]) < 4; c++) step();
    chk("t2_grants", ack_log.size(), 4);
    if (ack_log.size() == 4) begin
      chk("t2_grant0", ack_log[0], 0);
      chk("t2_grant1", ack_log[1], 1);
      chk("t2_grant2", ack_log[2], 2);
      chk("t2_grant3", ack_log[3], 0);
    end
    chk("t2_gap_min", min_gap >= GAP, 1'b1);

    // bad PID on requester 2, then a normal request on 0
    do_reset();
    enc_lat = 3;
    req_pkt[2] = mk_pkt(8'hFF);
    req_valid = 3'b100;
    for (int c = 0; c < 12; c++) step();
    chk("t3_err", err_cnt[2], 1);
    chk("t3_no_avail", hi_cnt, 0);
    req_pkt[0] = mk_pkt(8'hC3);
    req_valid[0] = 1'b1;
    for (int c = 0; c < 30; c++) step();
    chk("t3_next_done", done_cnt[0], 1);

    // requester changes its packet right after ack; stray pkt_sent
    do_reset();
    enc_lat = 12; chg_on_ack = 1; stray = 1;
    p0 = mk_pkt(8'h69);
    req_pkt[0] = p0;
    req_valid = 3'b001;
    for (int c = 0; c < 60 && done_cnt[0] == 0; c++) step();
    chk("t4_pkt_held", enc_pkt, p0);
    for (int c = 0; c < 40; c++) step();
    chk("t4_one_ack", ack_log.size(), 1);
    chk("t4_one_done", done_cnt[0], 1);
    chg_on_ack = 0; stray = 0;

    // reset in the middle of SEND
    do_reset();
    enc_hang = 1;
    req_pkt[1] = mk_pkt(8'hC3);
    req_valid = 3'b010;
    for (int c = 0; c < 20 && enc_pkt_avail !== 1'b1; c++) step();
    chk("t5_in_send", enc_pkt_avail, 1'b1);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_avail_busy", {enc_pkt_avail, busy}, 2'b00);
    chk("t5_no_pulses", {req_done, req_err}, '0);
    enc_hang = 0;
    clear();
    req_pkt[0] = mk_pkt(8'hD2);
    req_pkt[2] = mk_pkt(8'hD2);
    req_valid = 3'b101;
    for (int c = 0; c < 10 && ack_log.size() == 0; c++) step();
    chk("t5_ptr_cleared", ack_log.size() > 0 ? ack_log[0] : -1, 0);
    for (int c = 0; c < 80; c++) step();

    // encoder never answers
    do_reset();
    enc_hang = 1;
    req_pkt[0] = mk_pkt(8'hE1);
    req_valid = 3'b001;
    for (int c = 0; c < 300; c++) step();
`ifdef USB_TX_TIMEOUT_EN
    chk("t6_timeout_cycles", hi_cnt, TO);
    chk("t6_timeout_err", err_cnt[0], 1);
`else
    chk("t6_still_avail", enc_pkt_avail, 1'b1);
    chk("t6_no_err", err_cnt[0], 0);
`endif
    chk("t6_no_done", done_cnt[0], 0);
    enc_hang = 0;

    // randomized traffic
    do_reset();
    enc_rand = 1; stray = 1; rand_mode = 1;
    for (int c = 0; c < 4000; c++) step();
    rand_mode = 0;
    for (int c = 0; c < 3000 && !(req_valid == '0 && busy == 1'b0); c++) step();
    chk("drain_idle", {req_valid == '0, busy}, 2'b10);
    step(); step();
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
